// File: rtl/adc_sar_pkg.sv
// Shared constants and state encoding for the SAR ADC sequencer.
package adc_sar_pkg;

  localparam int unsigned ADC_BITS = 12;
  localparam logic [ADC_BITS-1:0] ADC_MIDSCALE = 12'h800;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DONE    = 3'd4
  } sar_state_t;

endpackage

// File: rtl/adc_sar_controller.sv
// Successive-approximation sequencer: sample phase, 12-step binary search,
// result word with a one-cycle valid strobe. All outputs come from flops.
// Optional macro ADC_COMP_SETTLE_EN inserts a SETTLE cycle before every
// comparator sample (two cycles per bit).
module adc_sar_controller
  import adc_sar_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comp_in,
  output logic                sample_en,
  output logic [ADC_BITS-1:0] dac_data,
  output logic                busy,
  output logic [ADC_BITS-1:0] result,
  output logic                result_valid
);

`ifdef ADC_COMP_SETTLE_EN
  localparam sar_state_t BIT_ENTRY = ST_SETTLE;
`else
  localparam sar_state_t BIT_ENTRY = ST_CONVERT;
`endif

  sar_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADC_BITS-1:0] trial_q, trial_d;
  logic [ADC_BITS-1:0] mask_q, mask_d;
  logic [ADC_BITS-1:0] result_q, result_d;
  logic [ADC_BITS-1:0] decided;
  logic                sample_en_q, sample_en_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  // State, datapath and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      trial_q     <= '0;
      mask_q      <= '0;
      result_q    <= '0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trial_q     <= trial_d;
      mask_q      <= mask_d;
      result_q    <= result_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state
  // so that each registered output is valid in the cycle its state occupies.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trial_d  = trial_q;
    mask_d   = mask_q;
    result_d = result_q;
    decided  = comp_in ? trial_q : (trial_q & ~mask_q);

    case (state_q)
      ST_IDLE: begin
        trial_d = '0;
        if (start) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end
      end
      ST_SAMPLE: begin
        trial_d = '0;
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = BIT_ENTRY;
          trial_d = ADC_MIDSCALE;
          mask_d  = ADC_MIDSCALE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef ADC_COMP_SETTLE_EN
      ST_SETTLE: begin
        state_d = ST_CONVERT;
      end
`endif
      ST_CONVERT: begin
        if (mask_q[0]) begin
          state_d  = ST_DONE;
          trial_d  = decided;
          result_d = decided;
          mask_d   = '0;
        end else begin
          state_d = BIT_ENTRY;
          mask_d  = mask_q >> 1;
          trial_d = decided | (mask_q >> 1);
        end
      end
      ST_DONE: begin
        trial_d = '0;
        if (start) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        trial_d = '0;
        mask_d  = '0;
      end
    endcase

    sample_en_d = (state_d == ST_SAMPLE);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = (state_d == ST_DONE);
  end

  assign sample_en    = sample_en_q;
  assign dac_data     = trial_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_adc_sar_controller.sv
// Self-checking bench for adc_sar_controller with an ideal comparator.
module tb_adc_sar_controller;
  import adc_sar_pkg::*;

  localparam int S = 2;
`ifdef ADC_COMP_SETTLE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int LAT = S + 12 * STEP + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        comp_in;
  logic [11:0] vin = 12'h000;
  logic        sample_en;
  logic [11:0] dac_data;
  logic        busy;
  logic [11:0] result;
  logic        result_valid;

  int n_pass = 0;
  int n_total = 0;
  logic [11:0] seen [12];

  typedef struct {
    logic [11:0] vin;
    logic [11:0] res;
  } vec_t;

  always #5 clk = ~clk;

  // Ideal comparator against the presented trial code.
  assign comp_in = (vin >= dac_data);

  adc_sar_controller #(.SAMPLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .comp_in(comp_in),
    .sample_en(sample_en), .dac_data(dac_data), .busy(busy),
    .result(result), .result_valid(result_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Trial code presented for bit b of an ideal binary search on v.
  function automatic logic [11:0] model_trial(input logic [11:0] v, input int b);
    int code = 0;
    for (int k = 11; k > b; k--) begin
      int t = code + (1 << k);
      if (int'(v) >= t) code = t;
    end
    return 12'(code + (1 << b));
  endfunction

  // Final word of an ideal binary search on v.
  function automatic logic [11:0] model_result(input logic [11:0] v);
    int code = 0;
    for (int k = 11; k >= 0; k--) begin
      int t = code + (1 << k);
      if (int'(v) >= t) code = t;
    end
    return 12'(code);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at edge 0; returns in cycle 1.
  task automatic launch(input logic [11:0] v);
    vin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_conv(input logic [11:0] v, input logic [11:0] exp_res, input string tag);
    launch(v);
    for (int c = 1; c <= LAT + 1; c++) begin
      logic [11:0] exp_dac;
      if (c <= S) exp_dac = 12'h000;
      else if (c < LAT) begin
        int b = 11 - (c - S - 1) / STEP;
        exp_dac = model_trial(v, b);
        seen[11 - b] = dac_data;
      end else if (c == LAT) exp_dac = exp_res;
      else exp_dac = 12'h000;
      chk({tag, " sample_en"}, 32'(sample_en), 32'(c <= S));
      chk({tag, " busy"}, 32'(busy), 32'(c <= LAT));
      chk({tag, " result_valid"}, 32'(result_valid), 32'(c == LAT));
      chk({tag, " dac_data"}, 32'(dac_data), 32'(exp_dac));
      if (c == LAT) chk({tag, " result"}, 32'(result), 32'(exp_res));
      if (c <= LAT) tick();
    end
    chk({tag, " result held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [5];
    logic [11:0] first4 [4];
    int          rc;

    tbl[0] = '{vin: 12'hA5C, res: 12'hA5C};
    tbl[1] = '{vin: 12'h000, res: 12'h000};
    tbl[2] = '{vin: 12'hFFF, res: 12'hFFF};
    tbl[3] = '{vin: 12'h3FF, res: 12'h3FF};
    tbl[4] = '{vin: 12'h123, res: 12'h123};
    first4[0] = 12'h800; first4[1] = 12'hC00; first4[2] = 12'hA00; first4[3] = 12'hB00;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst sample_en", 32'(sample_en), 32'd0);
    chk("rst dac_data", 32'(dac_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst result_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle busy", 32'(busy), 32'd0);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_conv(tbl[i].vin, tbl[i].res, $sformatf("vec%0d", i));
      if (i == 0)
        for (int k = 0; k < 4; k++) chk($sformatf("a5c trial%0d", k), 32'(seen[k]), 32'(first4[k]));
    end

    // Random vectors against the model
    for (int i = 0; i < 6; i++) begin
      logic [11:0] v;
      v = 12'($urandom_range(0, 4095));
      run_conv(v, model_result(v), $sformatf("rnd%0d", i));
    end

    // Start held through DONE: two back-to-back conversions, no idle gap
    vin = 12'h5A5;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 2 * LAT + 1; c++) begin
      chk($sformatf("b2b busy c%0d", c), 32'(busy), 32'(c <= 2 * LAT));
      chk($sformatf("b2b valid c%0d", c), 32'(result_valid), 32'(c == LAT || c == 2 * LAT));
      chk($sformatf("b2b sample_en c%0d", c), 32'(sample_en),
          32'((c >= 1 && c <= S) || (c >= LAT + 1 && c <= LAT + S)));
      if (c == 2 * LAT) chk("b2b result", 32'(result), 32'(model_result(12'h5A5)));
      if (c == LAT + 1) start = 1'b0;
      tick();
    end

    // Start pulse during CONVERT is ignored
    launch(12'h6B7);
    for (int c = 1; c <= LAT + 4; c++) begin
      chk($sformatf("ign valid c%0d", c), 32'(result_valid), 32'(c == LAT));
      chk($sformatf("ign busy c%0d", c), 32'(busy), 32'(c <= LAT));
      if (c == LAT) chk("ign result", 32'(result), 32'h6B7);
      start = (c == S + 4);
      tick();
    end
    start = 1'b0;

    // Reset during the bit-5 compare cycle
    rc = S + (11 - 5) * STEP + STEP;
    launch(12'h3FF);
    for (int c = 1; c < rc; c++) tick();
    chk("rstmid bit5 trial", 32'(dac_data), 32'(model_trial(12'h3FF, 5)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid sample_en", 32'(sample_en), 32'd0);
    chk("rstmid dac_data", 32'(dac_data), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid result", 32'(result), 32'd0);
    chk("rstmid result_valid", 32'(result_valid), 32'd0);
    tick();
    chk("rstmid stays idle busy", 32'(busy), 32'd0);
    chk("rstmid stays idle dac", 32'(dac_data), 32'd0);
    run_conv(12'h3FF, 12'h3FF, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
